// File: rtl/serial_rx_port_pkg.sv
// serial_defs: shared definitions for the serial receive port.
//   - RX FSM state encodings (3-bit localparams)
//   - DATA_BITS     : payload bits per 8N1 frame
//   - RX_IDLE_LEVEL : level of the idle line and of a valid stop bit
package serial_defs;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  localparam int   DATA_BITS     = 8;
  localparam logic RX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_rx_port_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clock, reset (async, active-low)
//   push, push_data : write request and data
//   pop             : read request; ignored while empty
//   head_data       : oldest entry, or zero when empty
//   empty, full     : occupancy flags
//   count           : occupancy 0..DEPTH
// A push while full is only accepted when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (ADDR_W+1)'(DEPTH));
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pop needs data; push needs a free slot or a simultaneous pop.
  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_rx_port.sv
// serial_rx_port: 8N1 serial receiver feeding a show-ahead byte FIFO.
//   clock, reset (async, active-low)
//   rx_in             : asynchronous serial line, idle high
//   serial_out        : FIFO head byte (zero when empty)
//   serial_valid_out  : FIFO non-empty
//   serial_rden_in    : one-cycle pop strobe
//   frame_err_out     : pulse when a stop bit is sampled low
//   overflow_out      : pulse when a completed byte is dropped on a full FIFO
//   fifo_count_out    : FIFO occupancy
module serial_rx_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_in,
  output logic [7:0]        serial_out,
  output logic              serial_valid_out,
  input  logic              serial_rden_in,
  output logic              frame_err_out,
  output logic              overflow_out,
  output logic [ADDR_W:0]   fifo_count_out
);

  import serial_defs::*;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  logic                 sync1_q, sync2_q, rx_s;
  logic [2:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overflow_q, overflow_d;
  logic                 push, baud_tick;
  logic                 fifo_empty, fifo_full;

  assign rx_s      = sync2_q;
  assign baud_tick = (baud_q == '0);

  // Two-flop synchroniser; resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= RX_IDLE_LEVEL;
      sync2_q <= RX_IDLE_LEVEL;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
    end
  end

  // Start is checked half a bit after the falling edge, so every later
  // sample lands in the middle of its bit. BREAK waits out a held-low
  // line after a framing error instead of reading it as a new start bit.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (rx_s != RX_IDLE_LEVEL) begin
          baud_d  = BAUD_HALF;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (!baud_tick) begin
          baud_d = baud_q - BAUD_W'(1);
        end else if (rx_s == RX_IDLE_LEVEL) begin
          state_d = RX_IDLE;
        end else begin
          baud_d  = BAUD_FULL;
          bit_d   = '0;
          state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (!baud_tick) begin
          baud_d = baud_q - BAUD_W'(1);
        end else begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          baud_d  = BAUD_FULL;
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (!baud_tick) begin
          baud_d = baud_q - BAUD_W'(1);
        end else if (rx_s == RX_IDLE_LEVEL) begin
          push    = 1'b1;
          state_d = RX_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rx_s == RX_IDLE_LEVEL) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // A push into a full FIFO is dropped unless a pop frees the slot this cycle.
  always_comb begin
    overflow_d = push && fifo_full && !serial_rden_in;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RX_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH  (DATA_BITS),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (shift_q),
    .pop       (serial_rden_in),
    .head_data (serial_out),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count_out)
  );

  assign serial_valid_out = !fifo_empty;
  assign frame_err_out    = frame_err_q;
  assign overflow_out     = overflow_q;

endmodule

// File: tb/tb_serial_rx_port.sv
// Directed bench for serial_rx_port with CLKS_PER_BIT = 16, FIFO_DEPTH = 16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_rx_port;

  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       rxIn;
  logic [7:0] serialOut;
  logic       serialValid;
  logic       serialRden;
  logic       frameErr;
  logic       overflow;
  logic [4:0] fifoCount;

  int vectorCount = 0;
  int missCount   = 0;
  int cycleCnt    = 0;
  int frameErrCount = 0;
  int overflowCount = 0;
  int validRiseCycle = -1;
  logic prevValid = 1'b0;

  serial_rx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (16),
    .ADDR_W       (4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .rx_in            (rxIn),
    .serial_out       (serialOut),
    .serial_valid_out (serialValid),
    .serial_rden_in   (serialRden),
    .frame_err_out    (frameErr),
    .overflow_out     (overflow),
    .fifo_count_out   (fifoCount)
  );

  // 10 ns clock and a free-running cycle counter for latency measurement
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycleCnt++;

  // Pulse counters and head-valid rise detection, sampled mid-cycle
  always @(negedge clock) begin
    if (reset) begin
      if (frameErr) frameErrCount++;
      if (overflow) overflowCount++;
      if (serialValid && !prevValid) validRiseCycle = cycleCnt;
      prevValid = serialValid;
    end else begin
      prevValid = 1'b0;
    end
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Sends one 8N1 frame starting at the current falling edge; a low stop
  // level is held for stopPeriods bit times and then released high.
  task automatic applyStimulus(input logic [7:0] data, input int stopPeriods,
                               input logic stopLevel);
    rxIn = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rxIn = data[i];
      repeat (CPB) @(negedge clock);
    end
    rxIn = stopLevel;
    repeat (CPB * stopPeriods) @(negedge clock);
    if (!stopLevel) begin
      rxIn = 1'b1;
      repeat (CPB) @(negedge clock);
    end
  endtask

  task automatic popByte(output logic [7:0] data);
    data = serialOut;
    serialRden = 1'b1;
    @(negedge clock);
    serialRden = 1'b0;
  endtask

  logic [7:0] got;
  int startCycle, latency, fe0, ov0;

  initial begin
    reset = 1'b0;
    rxIn = 1'b1;
    serialRden = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset state
    checkOutput("rst_valid", serialValid, 0);
    checkOutput("rst_data", serialOut, 8'h00);
    checkOutput("rst_count", fifoCount, 0);
    checkOutput("rst_frame", frameErr, 0);
    checkOutput("rst_ovf", overflow, 0);

    // Single byte with latency check (2 + 8 + 144 + 1 = 155 clocks)
    validRiseCycle = -1;
    startCycle = cycleCnt;
    applyStimulus(8'h41, 1, 1'b1);
    latency = validRiseCycle - startCycle;
    checkOutput("single_valid", serialValid, 1);
    checkOutput("single_data", serialOut, 8'h41);
    checkOutput("single_count", fifoCount, 1);
    checkOutput("single_latency",
                (latency >= 154 && latency <= 156) ? 32'd155 : latency, 155);
    popByte(got);
    checkOutput("single_pop", got, 8'h41);
    checkOutput("single_valid_after_pop", serialValid, 0);

    // Back-to-back frames without reads
    repeat (5) @(negedge clock);
    applyStimulus(8'h48, 1, 1'b1);
    applyStimulus(8'h69, 1, 1'b1);
    applyStimulus(8'h0A, 1, 1'b1);
    checkOutput("b2b_count", fifoCount, 3);
    popByte(got); checkOutput("b2b_pop0", got, 8'h48);
    popByte(got); checkOutput("b2b_pop1", got, 8'h69);
    popByte(got); checkOutput("b2b_pop2", got, 8'h0A);
    checkOutput("b2b_count_end", fifoCount, 0);

    // Short glitch must not produce a byte
    rxIn = 1'b0;
    repeat (4) @(negedge clock);
    rxIn = 1'b1;
    repeat (40) @(negedge clock);
    checkOutput("glitch_count", fifoCount, 0);
    checkOutput("glitch_valid", serialValid, 0);

    // Framing error, then a clean byte
    fe0 = frameErrCount;
    applyStimulus(8'h55, 2, 1'b0);
    repeat (20) @(negedge clock);
    checkOutput("frame_pulses", frameErrCount - fe0, 1);
    checkOutput("frame_count", fifoCount, 0);
    applyStimulus(8'hAA, 1, 1'b1);
    checkOutput("after_frame_count", fifoCount, 1);
    popByte(got);
    checkOutput("after_frame_data", got, 8'hAA);

    // Overflow on the 17th byte
    ov0 = overflowCount;
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1, 1'b1);
    checkOutput("fill_count", fifoCount, 16);
    checkOutput("fill_no_ovf", overflowCount - ov0, 0);
    applyStimulus(8'h10, 1, 1'b1);
    checkOutput("ovf_count", fifoCount, 16);
    checkOutput("ovf_pulses", overflowCount - ov0, 1);
    for (int i = 0; i < 16; i++) begin
      popByte(got);
      checkOutput("ovf_drain", got, 8'(i));
    end
    checkOutput("ovf_drain_count", fifoCount, 0);

    // Pop while empty is ignored
    popByte(got);
    checkOutput("empty_pop_data", got, 8'h00);
    checkOutput("empty_pop_count", fifoCount, 0);
    checkOutput("empty_pop_valid", serialValid, 0);

    // Pop coinciding with the stop-bit push while full
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h20 + i), 1, 1'b1);
    ov0 = overflowCount;
    fork
      applyStimulus(8'hC3, 1, 1'b1);
      begin
        repeat (154) @(negedge clock);
        serialRden = 1'b1;
        @(negedge clock);
        serialRden = 1'b0;
      end
    join
    checkOutput("full_pop_count", fifoCount, 16);
    checkOutput("full_pop_no_ovf", overflowCount - ov0, 0);
    checkOutput("full_pop_head", serialOut, 8'h21);
    for (int i = 1; i < 16; i++) begin
      popByte(got);
      checkOutput("full_pop_drain", got, 8'(8'h20 + i));
    end
    popByte(got);
    checkOutput("full_pop_last", got, 8'hC3);

    // Reset in the middle of a frame
    applyStimulus(8'h11, 1, 1'b1);
    checkOutput("pre_reset_count", fifoCount, 1);
    rxIn = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rxIn = (i == 0) ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clock);
    end
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_valid", serialValid, 0);
    checkOutput("mid_reset_count", fifoCount, 0);
    checkOutput("mid_reset_data", serialOut, 8'h00);
    rxIn = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    applyStimulus(8'h7E, 1, 1'b1);
    checkOutput("post_reset_count", fifoCount, 1);
    checkOutput("post_reset_data", serialOut, 8'h7E);
    popByte(got);
    checkOutput("post_reset_empty", serialValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
